// File: rtl/sram_arbiter_if.sv
// Bundle between the requester blocks, the arbiter and the single-port SRAM macro.
//
// Request handshake: requester i holds req_valid[i] and its
// req_wen/req_addr/req_wdata slice stable until it sees req_ready[i].
// A transfer happens on a rising edge where req_valid[i] && req_ready[i].
// req_ready never depends on anything but req_valid and the arbiter's state.
// Responses: rsp_valid[i] is a one-cycle pulse qualifying the shared rsp_rdata.
// Responses cannot be stalled.
interface sram_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 256
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_wen;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      sram_en;
    logic [ADDR_W-1:0]         sram_addr;
    logic [DATA_W-1:0]         sram_din;
    logic                      sram_wen;
    logic [DATA_W-1:0]         sram_dout;

    // Requester blocks plus the SRAM macro
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, sram_en, sram_addr, sram_din, sram_wen
    );

    // Arbiter
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, sram_en, sram_addr, sram_din, sram_wen
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM between NUM_REQ requesters.
// It accepts at most one access per cycle and drives registered SRAM controls.
// Read ids travel down a shift pipeline so read data returns to its requester.
module sram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 256,
    parameter int RD_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    rr_ptr;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      scan_pos;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_wen;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;

    logic               sram_en_q;
    logic               sram_wen_q;
    logic [ADDR_W-1:0]  sram_addr_q;
    logic [DATA_W-1:0]  sram_din_q;

    logic [RD_LAT:0]    rd_vld;
    logic [ID_W-1:0]    rd_id [RD_LAT+1];

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    // Find the first valid requester at or above the pointer, wrapping; nothing is granted in reset
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_pos  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_pos >= (ID_W+1)'(NUM_REQ)) begin
                scan_pos = scan_pos - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && bus.req_valid[scan_pos[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_pos[ID_W-1:0];
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    // Build the one-hot ready and select the winner's request fields
    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_id] = 1'b1;
        end
        grant_wen   = bus.req_wen[grant_id];
        grant_addr  = bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        grant_wdata = bus.req_wdata[int'(grant_id)*DATA_W +: DATA_W];
    end

    // Register the accepted access toward the SRAM and advance the pointer past the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            sram_en_q   <= 1'b0;
            sram_wen_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
        end else begin
            sram_en_q  <= grant_any;
            sram_wen_q <= grant_any && grant_wen;
            if (grant_any) begin
                rr_ptr      <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
                sram_addr_q <= grant_addr;
                sram_din_q  <= grant_wen ? grant_wdata : '0;
            end
        end
    end

    // Carry read ids alongside the SRAM latency; stage RD_LAT lines up with valid sram_dout
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                rd_id[k] <= '0;
            end
        end else begin
            rd_vld   <= {rd_vld[RD_LAT-1:0], grant_any && !grant_wen};
            rd_id[0] <= grant_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                rd_id[k] <= rd_id[k-1];
            end
        end
    end

    // Capture read data and pulse the owner's valid; the data register holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (rd_vld[RD_LAT]) begin
                rsp_valid_q <= NUM_REQ'(1) << rd_id[RD_LAT];
                rsp_rdata_q <= bus.sram_dout;
            end
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.sram_en   = sram_en_q;
    assign bus.sram_wen  = sram_wen_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_din  = sram_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a behavioural SRAM, directed scenarios plus random traffic,
// and a scoreboard that predicts every SRAM access, grant and read response.
module tb_sram_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 256;
    localparam int RD_LAT  = 1;

    typedef struct {
        int                due;
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } acc_t;

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    acc_t              acc_q[$];
    rsp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [int];
    int                model_ptr = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_din = '0;
    logic [DATA_W-1:0] last_rdata = '0;

    logic [DATA_W-1:0] sram_mem [int];
    logic [DATA_W-1:0] dout_pipe [RD_LAT];

    sram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SRAM (write-first, RD_LAT read latency) ----------------
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wen) begin
                sram_mem[int'(bus.sram_addr)] = bus.sram_din;
            end else begin
                dout_pipe[0] <= sram_mem.exists(int'(bus.sram_addr)) ? sram_mem[int'(bus.sram_addr)] : '0;
            end
        end
        for (int k = 1; k < RD_LAT; k++) dout_pipe[k] <= dout_pipe[k-1];
    end
    assign bus.sram_dout = dout_pipe[RD_LAT-1];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int s;
        s = $urandom_range(0, 7);
        if (s == 7) return 15'h7FFF;
        return ADDR_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    // ---------------- scoreboard monitor (negedge, away from the active edge) ----------------
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        logic [NUM_REQ-1:0] exp_rdy;
        int win;

        // SRAM port: either the predicted access or an idle cycle with held address/data
        if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
            a = acc_q.pop_front();
            check("sram_en", DATA_W'(bus.sram_en), DATA_W'(1'b1));
            check("sram_wen", DATA_W'(bus.sram_wen), DATA_W'(a.wen));
            check("sram_addr", DATA_W'(bus.sram_addr), DATA_W'(a.addr));
            check("sram_din", bus.sram_din, a.din);
            last_addr = a.addr;
            last_din  = a.din;
        end else begin
            check("sram_en_idle", DATA_W'(bus.sram_en), '0);
            check("sram_wen_idle", DATA_W'(bus.sram_wen), '0);
            check("sram_addr_hold", DATA_W'(bus.sram_addr), DATA_W'(last_addr));
            check("sram_din_hold", bus.sram_din, last_din);
        end

        // Responses: in accept order, RD_LAT+2 cycles after accept
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            check("rsp_valid", DATA_W'(bus.rsp_valid), DATA_W'(NUM_REQ'(1) << r.id));
            check("rsp_rdata", bus.rsp_rdata, r.data);
            last_rdata = r.data;
        end else begin
            check("rsp_valid_idle", DATA_W'(bus.rsp_valid), '0);
            check("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
        end

        // Round robin: first valid requester at or after the pointer, wrapping
        exp_rdy = '0;
        win = -1;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (model_ptr + k) % NUM_REQ;
                if (win < 0 && bus.req_valid[j]) win = j;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", DATA_W'(bus.req_ready), DATA_W'(exp_rdy));

        if (win >= 0) begin
            a.due  = cyc + 1;
            a.wen  = bus.req_wen[win];
            a.addr = bus.req_addr[win*ADDR_W +: ADDR_W];
            a.din  = a.wen ? bus.req_wdata[win*DATA_W +: DATA_W] : '0;
            acc_q.push_back(a);
            if (a.wen) begin
                ref_mem[int'(a.addr)] = a.din;
            end else begin
                r.due  = cyc + RD_LAT + 2;
                r.id   = win;
                r.data = ref_read(a.addr);
                exp_q.push_back(r);
            end
            model_ptr = (win + 1) % NUM_REQ;
        end

        // The coming edge resets the DUT: pending work is discarded
        if (rst) begin
            acc_q.delete();
            exp_q.delete();
            model_ptr  = 0;
            last_addr  = '0;
            last_din   = '0;
            last_rdata = '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic wen, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
        bus.req_valid[i] = 1'b1;
        bus.req_wen[i]   = wen;
        bus.req_addr[i*ADDR_W +: ADDR_W]  = addr;
        bus.req_wdata[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    // Hold a request until accepted (bounded), then drop it
    task automatic issue(input int i, input logic wen, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
        logic got;
        got = 1'b0;
        set_req(i, wen, addr, data);
        for (int k = 0; k < 4*NUM_REQ && !got; k++) begin
            @(negedge clk);
            got = bus.req_ready[i] && !rst;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout req=%0d got=0 exp=1", i);
        end
        bus.req_valid[i] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_REQ-1:0] acc;
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Single write then read of the same address
        issue(0, 1'b1, 15'h0010, {32{8'hA5}});
        issue(0, 1'b0, 15'h0010, '0);
        idle(6);

        // Four continuous readers from reset: 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, ADDR_W'(16 + i), '0);
        idle(12);
        bus.req_valid = '0;
        idle(5);

        // Pointer at 2 with req1 and req3 contending
        do_reset();
        issue(1, 1'b1, 15'h0003, rand_data());
        fork
            issue(1, 1'b0, 15'h0003, '0);
            issue(3, 1'b0, 15'h0010, '0);
        join
        idle(6);

        // Write then immediate read of 0x7FFF from another requester
        do_reset();
        fork
            issue(0, 1'b1, 15'h7FFF, DATA_W'(1));
            issue(1, 1'b0, 15'h7FFF, '0);
        join
        idle(6);

        // Reset the cycle after a read accept; pointer must restart at 0
        issue(0, 1'b0, 15'h0010, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        fork
            issue(0, 1'b0, 15'h7FFF, '0);
            issue(2, 1'b0, 15'h0010, '0);
        join
        idle(8);

        // req0 holds while req2 pulses valid between edges only
        set_req(0, 1'b0, 15'h0003, '0);
        idle(2);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            set_req(2, 1'b1, 15'h0005, rand_data());
            #2;
            bus.req_valid[2] = 1'b0;
        end
        idle(2);
        bus.req_valid = '0;
        idle(6);

        // Random traffic, requests held until accepted, one reset midway
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            rst = (c == 200);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 45) begin
                        set_req(i, 1'($urandom_range(0, 1)), rand_addr(), rand_data());
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        rst = 1'b0;
        bus.req_valid = '0;
        idle(10);

        checks++;
        if (acc_q.size() + exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", acc_q.size() + exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
